// File: rtl/uart16550_pkg.sv
// Shared UART 16550 types and helpers used by both the TX and RX engines.
package uart16550_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    function automatic logic [3:0] data_bit_count(input logic [1:0] wls);
        return 4'd5 + {2'b00, wls};
    endfunction

    // Parity over the active data bits only; stick parity overrides to ~eps.
    function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] wls,
                                         input logic eps, input logic sticky);
        logic [7:0] mask;
        logic       x;
        unique case (wls)
            WLS_5:   mask = 8'h1F;
            WLS_6:   mask = 8'h3F;
            WLS_7:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        x = ^(data & mask);
        if (sticky)
            return ~eps;
        return eps ? x : ~x;
    endfunction

endpackage

// File: rtl/uart16550_tx_engine.sv
// UART 16550 transmit shift engine: pops characters from the TX FIFO and
// serialises start/data/parity/stop bits onto tx, timed by baud_pulse.
module uart16550_tx_engine
    import uart16550_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_pop,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_par,
    input  logic       set_break,
    output logic       tx,
    output logic       tsr_empty,
    output logic       frame_done
);

    localparam int TW = $clog2(2 * OVERSAMPLE);
    localparam logic [TW-1:0] LIM_1  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] LIM_15 = TW'(3 * OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LIM_2  = TW'(2 * OVERSAMPLE - 1);

    tx_state_t     state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    wls_q, wls_d;
    logic          stb_q, stb_d;
    logic          pen_q, pen_d;
    logic          eps_q, eps_d;
    logic          stk_q, stk_d;
    logic          tx_q, tx_d;
    logic          tsr_empty_q, tsr_empty_d;

    logic          pop;
    logic          done;
    logic [TW-1:0] bit_lim;
    logic          bit_end;
    logic [2:0]    last_idx;

    always_comb begin
        bit_lim = LIM_1;
        if (state_q == TX_STOP && stb_q)
            bit_lim = (wls_q == WLS_5) ? LIM_15 : LIM_2;
    end

    assign bit_end  = baud_pulse && (tick_q == bit_lim);
    assign last_idx = 3'(data_bit_count(wls_q) - 4'd1);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        done    = 1'b0;

        if (state_q != TX_IDLE && baud_pulse)
            tick_d = tick_q + 1'b1;

        unique case (state_q)
            TX_IDLE: begin
                tick_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    idx_d   = '0;
                    tick_d  = '0;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    tick_d = '0;
                    if (idx_q == last_idx)
                        state_d = pen_q ? TX_PARITY : TX_STOP;
                    else
                        idx_d = idx_q + 3'd1;
                end
            end
            TX_PARITY: begin
                if (bit_end) begin
                    state_d = TX_STOP;
                    tick_d  = '0;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    done   = 1'b1;
                    tick_d = '0;
                    // Back-to-back frames: reload straight into START with no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Line settings are captured with the character so mid-frame writes wait for the next frame.
    always_comb begin
        data_d = data_q;
        wls_d  = wls_q;
        stb_d  = stb_q;
        pen_d  = pen_q;
        eps_d  = eps_q;
        stk_d  = stk_q;
        if (pop) begin
            data_d = fifo_dout;
            wls_d  = wls;
            stb_d  = stb;
            pen_d  = pen;
            eps_d  = eps;
            stk_d  = sticky_par;
        end
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = data_q[idx_d];
            TX_PARITY: tx_d = calc_parity(data_q, wls_q, eps_q, stk_q);
            default:   tx_d = 1'b1;
        endcase
        tsr_empty_d = (state_d == TX_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= TX_IDLE;
            tick_q      <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            wls_q       <= WLS_5;
            stb_q       <= 1'b0;
            pen_q       <= 1'b0;
            eps_q       <= 1'b0;
            stk_q       <= 1'b0;
            tx_q        <= 1'b1;
            tsr_empty_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            wls_q       <= wls_d;
            stb_q       <= stb_d;
            pen_q       <= pen_d;
            eps_q       <= eps_d;
            stk_q       <= stk_d;
            tx_q        <= tx_d;
            tsr_empty_q <= tsr_empty_d;
        end
    end

    // pop/done are combinational; masking with rst keeps the FIFO untouched while reset is held.
    assign fifo_pop   = pop & ~rst;
    assign frame_done = done & ~rst;
    assign tx         = tx_q & ~set_break;
    assign tsr_empty  = tsr_empty_q;

endmodule

// File: tb/tb_uart16550_tx_engine.sv
// Self-checking bench for uart16550_tx_engine: directed frames from the test plan
// plus randomized back-to-back groups, compared against a bit-list frame model.
module tb_uart16550_tx_engine;

    localparam int OS = 16;

    typedef struct {
        logic [7:0] data;
        logic [1:0] wls;
        logic       stb;
        logic       pen;
        logic       eps;
        logic       stk;
        int         brk_at;
        int         brk_len;
    } frm_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_pulse = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_pop;
    logic [1:0] wls = 2'b11;
    logic       stb = 1'b0;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sticky_par = 1'b0;
    logic       set_break = 1'b0;
    logic       tx;
    logic       tsr_empty;
    logic       frame_done;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [0:255];
    logic [7:0] rd_ptr = 8'd0;
    logic [7:0] wr_ptr = 8'd0;
    int         pops = 0;
    int         pushes = 0;
    int         dones = 0;
    int         exp_done = 0;
    int         underrun = 0;
    frm_t       flist[$];

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_dout  = mem[rd_ptr];

    uart16550_tx_engine #(.OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .baud_pulse(baud_pulse),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_pop(fifo_pop),
        .wls(wls), .stb(stb), .pen(pen), .eps(eps), .sticky_par(sticky_par),
        .set_break(set_break), .tx(tx), .tsr_empty(tsr_empty), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_pop) begin
            rd_ptr <= rd_ptr + 8'd1;
            pops   <= pops + 1;
            if (fifo_empty) underrun <= underrun + 1;
        end
        if (frame_done) dones <= dones + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic frm_t mk(input logic [7:0] d, input logic [1:0] w, input logic s,
                                input logic p, input logic e, input logic k,
                                input int ba, input int bl);
        frm_t f;
        f.data = d; f.wls = w; f.stb = s; f.pen = p; f.eps = e; f.stk = k;
        f.brk_at = ba; f.brk_len = bl;
        return f;
    endfunction

    task automatic apply(input frm_t f);
        wls = f.wls; stb = f.stb; pen = f.pen; eps = f.eps; sticky_par = f.stk;
    endtask

    task automatic scramble();
        wls = 2'($urandom); stb = 1'($urandom); pen = 1'($urandom);
        eps = 1'($urandom); sticky_par = 1'($urandom);
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
        pushes++;
    endtask

    // Reference frame: list of (level, duration in bit-clock pulses).
    task automatic build(input frm_t f, output logic vals[12], output int durs[12], output int nb);
        int nd, ones;
        nd = 5 + int'(f.wls);
        ones = 0;
        vals[0] = 1'b0; durs[0] = OS;
        for (int i = 0; i < nd; i++) begin
            vals[1 + i] = f.data[i];
            durs[1 + i] = OS;
            ones += int'(f.data[i]);
        end
        nb = 1 + nd;
        if (f.pen) begin
            if (f.stk)      vals[nb] = ~f.eps;
            else if (f.eps) vals[nb] = 1'((ones % 2) == 1);
            else            vals[nb] = 1'((ones % 2) == 0);
            durs[nb] = OS;
            nb++;
        end
        vals[nb] = 1'b1;
        durs[nb] = !f.stb ? OS : (f.wls == 2'b00 ? OS * 3 / 2 : OS * 2);
        nb++;
    endtask

    // Transmit flist back-to-back and check every cycle of every frame.
    task automatic run_group(input bit do_push);
        int n, t;
        n = flist.size();
        if (do_push) begin
            @(negedge clk);
            apply(flist[0]);
            foreach (flist[i]) push(flist[i].data);
        end
        #1;
        for (t = 0; t < 50 && !fifo_pop; t++) begin
            @(negedge clk); #1;
        end
        if (!fifo_pop) begin
            chk("pop_wait", 32'd0, 32'd1);
            return;
        end
        for (int k = 0; k < n; k++) begin
            logic vals[12];
            int   durs[12];
            int   nb, total, cyc;
            logic tsr_hi, pop_bad, done_bad, last_done, last_pop;
            build(flist[k], vals, durs, nb);
            total = 0;
            for (int b = 0; b < nb; b++) total += durs[b];
            cyc = 0; tsr_hi = 0; pop_bad = 0; done_bad = 0; last_done = 0; last_pop = 0;
            for (int b = 0; b < nb; b++) begin
                logic [31:0] got, exp;
                got = '0; exp = '0;
                for (int d = 0; d < durs[b]; d++) begin
                    @(negedge clk);
                    set_break = (cyc >= flist[k].brk_at) && (cyc < flist[k].brk_at + flist[k].brk_len);
                    if (cyc == 2) scramble();
                    if (cyc == total - 3 && k + 1 < n) apply(flist[k + 1]);
                    #1;
                    got[d] = tx;
                    exp[d] = set_break ? 1'b0 : vals[b];
                    tsr_hi |= tsr_empty;
                    if (cyc == total - 1) begin
                        last_done = frame_done;
                        last_pop  = fifo_pop;
                    end else begin
                        pop_bad  |= fifo_pop;
                        done_bad |= frame_done;
                    end
                    cyc++;
                end
                chk($sformatf("f%0d_bit%0d_tx", k, b), got, exp);
            end
            set_break = 1'b0;
            exp_done++;
            chk($sformatf("f%0d_done_end", k), 32'(last_done), 32'd1);
            chk($sformatf("f%0d_done_early", k), 32'(done_bad), 32'd0);
            chk($sformatf("f%0d_pop_mid", k), 32'(pop_bad), 32'd0);
            chk($sformatf("f%0d_pop_next", k), 32'(last_pop), 32'(k + 1 < n));
            chk($sformatf("f%0d_tsr_busy", k), 32'(tsr_hi), 32'd0);
        end
        @(negedge clk); #1;
        chk("tsr_after", 32'(tsr_empty), 32'd1);
        chk("tx_idle", 32'(tx), 32'd1);
    endtask

    initial begin
        // Reset state, with a word already waiting to prove no pop during reset.
        apply(mk(8'hA5, 2'b11, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        push(8'hA5);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_tsr", 32'(tsr_empty), 32'd1);
        chk("rst_pop", 32'(fifo_pop), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        rst = 1'b0;

        flist = {mk(8'hA5, 2'b11, 0, 0, 0, 0, 0, 0)};
        run_group(0);
        flist = {mk(8'hFF, 2'b10, 0, 1, 1, 0, 0, 0)}; run_group(1);
        flist = {mk(8'hFF, 2'b10, 0, 1, 0, 0, 0, 0)}; run_group(1);
        flist = {mk(8'hFF, 2'b10, 0, 1, 1, 1, 0, 0)}; run_group(1);
        flist = {mk(8'h1F, 2'b00, 1, 0, 0, 0, 0, 0)}; run_group(1);
        flist = {mk(8'h2A, 2'b01, 1, 0, 0, 0, 0, 0)}; run_group(1);
        flist = {mk(8'h11, 2'b11, 0, 0, 0, 0, 0, 0),
                 mk(8'hC3, 2'b00, 1, 1, 0, 0, 0, 0),
                 mk(8'h7E, 2'b10, 1, 1, 1, 0, 0, 0)};
        run_group(1);
        flist = {mk(8'hA5, 2'b11, 0, 0, 0, 0, 40, 10)}; run_group(1);

        // Reset in DATA bit 3 with a second word queued.
        @(negedge clk);
        apply(mk(8'h3C, 2'b11, 0, 0, 0, 0, 0, 0));
        push(8'h3C); push(8'h96);
        #1;
        chk("rt_pop", 32'(fifo_pop), 32'd1);
        repeat (OS + 3 * OS + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rt_tx", 32'(tx), 32'd1);
        chk("rt_tsr", 32'(tsr_empty), 32'd1);
        chk("rt_pop0", 32'(fifo_pop), 32'd0);
        @(negedge clk); #1;
        chk("rt_pop1", 32'(fifo_pop), 32'd0);
        apply(mk(8'h96, 2'b11, 0, 1, 1, 0, 0, 0));
        rst = 1'b0;
        flist = {mk(8'h96, 2'b11, 0, 1, 1, 0, 0, 0)};
        run_group(0);

        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(1, 3);
            flist = {};
            for (int i = 0; i < n; i++) begin
                int ba, bl;
                ba = 0; bl = 0;
                if ($urandom_range(0, 2) == 0) begin
                    ba = $urandom_range(5, 60);
                    bl = $urandom_range(1, 20);
                end
                flist.push_back(mk(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                                   1'($urandom), 1'($urandom), ba, bl));
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run_group(1);
        end

        @(negedge clk);
        chk("pop_count", 32'(pops), 32'(pushes));
        chk("done_count", 32'(dones), 32'(exp_done));
        chk("underrun", 32'(underrun), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
